// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: function codes, FSM states and
// per-function execute latency.
package alu_pkg;

    localparam logic [5:0] FuncNone = 6'b000000;
    localparam logic [5:0] FuncAdd  = 6'b100000;
    localparam logic [5:0] FuncSub  = 6'b100010;
    localparam logic [5:0] FuncAnd  = 6'b100100;
    localparam logic [5:0] FuncOr   = 6'b100101;
    localparam logic [5:0] FuncNot  = 6'b100111;
    localparam logic [5:0] FuncBrfl = 6'b111111;
    localparam logic [5:0] FuncMul  = 6'b011000;
    localparam logic [5:0] FuncDiv  = 6'b011010;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    function automatic logic func_supported(input logic [5:0] func);
        case (func)
            FuncAdd, FuncSub, FuncAnd, FuncOr, FuncNot, FuncBrfl, FuncMul, FuncDiv: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic func_sets_flags(input logic [5:0] func);
        case (func)
            FuncAdd, FuncSub, FuncMul, FuncDiv: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] func_latency(input logic [5:0] func,
                                                input logic [3:0] mul_cycles,
                                                input logic [3:0] div_cycles);
        case (func)
            FuncMul: return mul_cycles;
            FuncDiv: return div_cycles;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences one operation at a time through an external multi-cycle ALU,
// holding operands stable for the function's latency and owning the flags register.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic [5:0]  req_func,
    input  logic        req_flags_we,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [5:0]  alu_func,
    output logic [2:0]  alu_flags_in,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_error,
    output logic [2:0]  flags
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] op1_q, op1_d, op2_q, op2_d;
    logic [5:0]  func_q, func_d;
    logic        flags_we_q, flags_we_d;
    logic        err_q, err_d;
    logic [31:0] result_q, result_d;
    logic        rsp_error_q, rsp_error_d;
    logic [2:0]  flags_q, flags_d;

    logic       req_err;
    logic [3:0] req_lat;

    // Divide-by-zero and unknown functions never reach the ALU; they complete in one cycle.
    assign req_err = !func_supported(req_func) || (req_func == FuncDiv && req_op2 == '0);
    assign req_lat = req_err ? 4'd1
                   : func_latency(req_func, 4'(MUL_CYCLES), 4'(DIV_CYCLES));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        func_d      = func_q;
        flags_we_d  = flags_we_q;
        err_d       = err_q;
        result_d    = result_q;
        rsp_error_d = rsp_error_q;
        flags_d     = flags_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op1_d      = req_op1;
                    op2_d      = req_op2;
                    func_d     = req_func;
                    flags_we_d = req_flags_we;
                    err_d      = req_err;
                    cnt_d      = req_lat - 4'd1;
                    state_d    = StExec;
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    state_d     = StResp;
                    rsp_error_d = err_q;
                    result_d    = err_q ? '0 : alu_result;
                    if (err_q) begin
                        if (func_q == FuncDiv && flags_we_q) begin
                            flags_d[0] = 1'b1;
                        end
                    end else if (flags_we_q && func_sets_flags(func_q)) begin
                        flags_d = alu_flags_out;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            func_q      <= FuncNone;
            flags_we_q  <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            rsp_error_q <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            func_q      <= func_d;
            flags_we_q  <= flags_we_d;
            err_q       <= err_d;
            result_q    <= result_d;
            rsp_error_q <= rsp_error_d;
            flags_q     <= flags_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign rsp_valid    = (state_q == StResp);
    assign alu_op1      = op1_q;
    assign alu_op2      = op2_q;
    assign alu_func     = (state_q == StExec && !err_q) ? func_q : FuncNone;
    assign alu_flags_in = flags_q;
    assign rsp_result   = result_q;
    assign rsp_error    = rsp_error_q;
    assign flags        = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural multi-cycle ALU plus a
// transaction-level model of results, errors, flags and latency.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int unsigned MulCyc = 4;
    localparam int unsigned DivCyc = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_op1 = '0, req_op2 = '0;
    logic [5:0]  req_func = '0;
    logic        req_flags_we = 1'b0;
    logic [31:0] alu_op1, alu_op2;
    logic [5:0]  alu_func;
    logic [2:0]  alu_flags_in;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic [2:0]  flags;

    int n_pass = 0;
    int n_checks = 0;
    logic [2:0] m_flags = '0;

    always #5 clock = ~clock;

    alu_sequencer #(.MUL_CYCLES(MulCyc), .DIV_CYCLES(DivCyc)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_func(req_func), .req_flags_we(req_flags_we),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func), .alu_flags_in(alu_flags_in),
        .alu_result(alu_result), .alu_flags_out(alu_flags_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .flags(flags)
    );

    // Reference ALU semantics; flags are {above, equals, overflow}.
    function automatic void ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] fl, output logic [31:0] r,
                                    output logic [2:0] fo);
        logic ovf;
        ovf = 1'b0;
        case (f)
            FuncAdd: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            FuncSub: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            FuncAnd: r = a & b;
            FuncOr:  r = a | b;
            FuncNot: r = ~a;
            FuncMul: r = 32'($signed(a) * $signed(b));
            FuncDiv: r = (b == '0) ? 32'h0000_dead : 32'($signed(a) / $signed(b));
            FuncBrfl: r = {31'b0, |(fl & a[2:0])};
            default: r = 32'hbad0_0bad;
        endcase
        fo = {($signed(a) > $signed(b)), (a == b), ovf};
    endfunction

    // Multi-cycle ALU: result only valid once inputs have been stable for the latency.
    int unsigned stab = 0;
    logic [5:0]  prev_func = '0;
    always @(posedge clock) begin
        if (reset || alu_func == FuncNone) stab <= 0;
        else if (alu_func == prev_func) stab <= stab + 1;
        else stab <= 1;
        prev_func <= alu_func;
    end

    logic [31:0] alu_r;
    logic [2:0]  alu_fo;
    int unsigned need;
    always_comb begin
        alu_r = '0;
        alu_fo = '0;
        ref_alu(alu_func, alu_op1, alu_op2, alu_flags_in, alu_r, alu_fo);
        need = (alu_func == FuncMul) ? MulCyc : (alu_func == FuncDiv) ? DivCyc : 1;
        if (stab + 1 >= need) begin
            alu_result    = alu_r;
            alu_flags_out = alu_fo;
        end else begin
            alu_result    = 32'hbad0_bad0;
            alu_flags_out = ~alu_fo;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Entered and left at a negedge with the sequencer idle.
    task automatic do_txn(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic we, input int hold, input bit poke,
                          output logic [31:0] res, output logic err);
        logic [31:0] er;
        logic [2:0]  fo, efl;
        logic        eerr;
        int          lat, n;
        eerr = !(f inside {FuncAdd, FuncSub, FuncAnd, FuncOr, FuncNot, FuncBrfl, FuncMul, FuncDiv})
               || (f == FuncDiv && b == 0);
        lat = eerr ? 1 : (f == FuncMul) ? int'(MulCyc) : (f == FuncDiv) ? int'(DivCyc) : 1;
        ref_alu(f, a, b, m_flags, er, fo);
        efl = m_flags;
        if (eerr) begin
            er = '0;
            if (f == FuncDiv && we) efl[0] = 1'b1;
        end else if (we && f inside {FuncAdd, FuncSub, FuncMul, FuncDiv}) begin
            efl = fo;
        end

        chk("idle_req_ready", req_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_flags", flags, m_flags);
        req_valid = 1'b1; req_func = f; req_op1 = a; req_op2 = b; req_flags_we = we;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0; req_op1 = $urandom; req_op2 = $urandom;
        req_func = 6'($urandom); req_flags_we = 1'($urandom);
        n = 0;
        while (!rsp_valid && n < 40) begin
            chk("exec_req_ready", req_ready, 0);
            chk("exec_op1", alu_op1, a);
            chk("exec_op2", alu_op2, b);
            if (!eerr) chk("exec_func", alu_func, f);
            chk("exec_flags_in", alu_flags_in, m_flags);
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        chk("latency", 32'(n), 32'(lat));
        m_flags = efl;
        res = rsp_result;
        err = rsp_error;
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", rsp_valid, 1);
            chk("resp_req_ready", req_ready, 0);
            chk("resp_result", rsp_result, er);
            chk("resp_error", rsp_error, eerr);
            chk("resp_flags", flags, m_flags);
            chk("resp_flags_in", alu_flags_in, m_flags);
            chk("resp_alu_func", alu_func, FuncNone);
            rsp_ready = (h == hold);
            if (h == hold && poke) begin
                req_valid = 1'b1; req_func = FuncAdd; req_op1 = $urandom; req_op2 = $urandom;
            end
            @(posedge clock);
            @(negedge clock);
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_op1_held", alu_op1, a);
        chk("post_alu_func", alu_func, FuncNone);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] res, a, b;
        logic        err;
        logic [5:0]  f;
        logic [5:0]  funcs [9];
        funcs = '{FuncAdd, FuncSub, FuncAnd, FuncOr, FuncNot, FuncBrfl, FuncMul, FuncDiv, 6'b000001};

        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_flags", flags, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_error", rsp_error, 0);
        chk("rst_alu_func", alu_func, 0);

        do_txn(FuncAdd, 32'd5, 32'd7, 1'b1, 0, 1'b0, res, err);
        chk("lit_add_result", res, 32'd12);
        chk("lit_add_error", err, 0);
        do_txn(FuncMul, 32'd3, -32'sd4, 1'b0, 1, 1'b1, res, err);
        chk("lit_mul_result", res, 32'hffff_fff4);
        do_txn(FuncSub, 32'd9, 32'd9, 1'b1, 0, 1'b0, res, err);
        chk("lit_sub_flags", flags, 3'b010);
        do_txn(FuncBrfl, 32'b010, 32'd0, 1'b0, 0, 1'b0, res, err);
        chk("lit_brfl_result", res, 32'd1);
        do_txn(FuncDiv, 32'd10, 32'd0, 1'b1, 5, 1'b1, res, err);
        chk("lit_div0_result", res, 0);
        chk("lit_div0_error", err, 1);
        chk("lit_div0_flags", flags, 3'b011);
        do_txn(6'b000001, 32'd1, 32'd2, 1'b1, 0, 1'b0, res, err);
        chk("lit_unsup_error", err, 1);
        chk("lit_unsup_flags", flags, 3'b011);

        for (int i = 0; i < 200; i++) begin
            f = funcs[$urandom_range(0, 8)];
            if (f == 6'b000001) f = 6'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = a;
                2: begin a = 32'($urandom_range(0, 20)); b = 32'($urandom_range(0, 20)); end
                default: ;
            endcase
            do_txn(f, a, b, 1'($urandom), $urandom_range(0, 3), 1'($urandom), res, err);
        end

        // Abort a DIV in its third execute cycle.
        do_txn(FuncSub, 32'd4, 32'd4, 1'b1, 0, 1'b0, res, err);
        req_valid = 1'b1; req_func = FuncDiv; req_op1 = 32'd100; req_op2 = 32'd7;
        req_flags_we = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        rsp_ready = 1'b0;
        m_flags = '0;
        chk("abort_req_ready", req_ready, 1);
        chk("abort_flags", flags, 0);
        chk("abort_result", rsp_result, 0);
        chk("abort_error", rsp_error, 0);
        for (int i = 0; i < 12; i++) begin
            chk("abort_no_rsp", rsp_valid, 0);
            @(posedge clock);
            @(negedge clock);
        end
        do_txn(FuncAdd, 32'h7fff_ffff, 32'd1, 1'b1, 0, 1'b0, res, err);
        chk("lit_add_ovf_flags", flags, 3'b101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 4, ALU execute cycles for MUL (func 011000); legal range 1..15.
REQ-002 Parameter DIV_CYCLES, default 8, ALU execute cycles for DIV (func 011010); legal range 1..15.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  core presents an operation.
REQ-006 req_ready  out  1  sequencer accepts an operation this cycle.
REQ-007 req_op1 / req_op2  in  32 each  signed operands.
REQ-008 req_func  in  6  ALU function code.
REQ-009 req_flags_we  in  1  commit ALU flags to the flags register at completion.
REQ-010 alu_op1 / alu_op2  out  32 each  operands driven to the ALU.
REQ-011 alu_func  out  6  function driven to the ALU.
REQ-012 alu_flags_in  out  3  flags register value ({above, equals, overflow}) driven to the ALU.
REQ-013 alu_result  in  32  ALU result.
REQ-014 alu_flags_out  in  3  ALU flags.
REQ-015 rsp_valid  out  1  response available.
REQ-016 rsp_ready  in  1  core consumes response.
REQ-017 rsp_result  out  32  captured result.
REQ-018 rsp_error  out  1  divide-by-zero or unsupported func.
REQ-019 flags  out  3  architectural flags register.

Function
REQ-020 FSM states IDLE, EXEC, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-021 IDLE: on req_valid&&req_ready, latch op1, op2, func, flags_we; load latency counter with L-1; go EXEC.
REQ-022 L=1 for ADD 100000, SUB 100010, AND 100100, OR 100101, NOT 100111, BRFL 111111; L=MUL_CYCLES for MUL; L=DIV_CYCLES for DIV.
REQ-023 EXEC: alu_op1/op2/func driven from latched registers, stable for all L cycles; counter decrements each cycle; at counter 0 capture alu_result into rsp_result and go RESP.
REQ-024 Latency: request accepted at edge k -> rsp_valid high in cycle k+L+1.
REQ-025 RESP: hold rsp_result, rsp_error stable until rsp_valid&&rsp_ready, then IDLE; no new request accepted in the same cycle.
REQ-026 alu_flags_in always equals flags register; BRFL therefore compares against committed flags.
REQ-027 At completion, if flags_we=1 and func is ADD/SUB/MUL/DIV, flags <= alu_flags_out; otherwise flags unchanged.
REQ-028 DIV with op2=0: skip EXEC (L treated as 1, ALU result ignored), rsp_result=0, rsp_error=1, flags[0] set to 1 if flags_we, other bits unchanged.
REQ-029 Unsupported func: rsp_result=0, rsp_error=1, flags unchanged, latency L=1.
REQ-030 Outside EXEC, alu_func is driven 000000 and alu_op1/op2 hold last latched values.

Reset
REQ-031 Reset forces IDLE, counter 0, flags=000, rsp_result=0, rsp_error=0, rsp_valid=0, req_ready=1 next cycle.
REQ-032 Reset in EXEC or RESP aborts the operation; no response and no flags update are produced.
REQ-033 Reset dominates simultaneous req_valid or rsp_ready.

Structure
REQ-034 Shared package alu_pkg holds func code constants, state enum, and the func-to-latency function.
REQ-035 No sub-module; the ALU is instantiated by the parent and connected via alu_* ports.

Verification
REQ-036 Reset, then ADD 5+7 with flags_we=1 -> rsp_valid at k+2, rsp_result=12, rsp_error=0.
REQ-037 MUL 3*(-4), MUL_CYCLES=4 -> rsp_valid at k+5, rsp_result=-12, alu_* stable for 4 EXEC cycles.
REQ-038 SUB 9-9 flags_we=1, then BRFL op1=010 -> flags=010, BRFL rsp_result=1.
REQ-039 DIV 10/0 flags_we=1 -> rsp_valid at k+2, rsp_result=0, rsp_error=1, flags[0]=1.
REQ-040 rsp_ready held low 5 cycles after rsp_valid -> response stable, req_ready=0 throughout; new req accepted cycle after handshake.
REQ-041 Reset asserted mid-DIV (EXEC cycle 3) -> IDLE next cycle, rsp_valid never asserts, flags=000.
